// File: rtl/f1_light_monitor.sv
// f1_light_monitor
//   Consumer end of the F1 start-light bus. Follows the thermometer light
//   pattern from the sequence FSM, checks that it steps legally
//   (00 -> 01 -> 03 -> ... -> all-on -> 00), and measures reaction time from
//   lights-out to the trigger press, counted in 'tick' strobes.
//
// Ports
//   clk           clock
//   rst           asynchronous active-high reset
//   lights_in     [WIDTH-1:0] light pattern, synchronous to clk
//   tick          one-cycle time-base strobe
//   trigger       driver button level; its rising edge is used
//   lights_level  [3:0] lit-light count of the last legal pattern
//   busy          high while the monitor is not idle
//   react_time    [CNT_W-1:0] last measured reaction time (held)
//   time_valid    one-cycle pulse when react_time updates
//   false_start   sticky early-press flag, cleared when a new sequence arms
//   pattern_err   one-cycle pulse on an illegal pattern or illegal step
module f1_light_monitor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lights_in,
  input  logic             tick,
  input  logic             trigger,
  output logic [3:0]       lights_level,
  output logic             busy,
  output logic [CNT_W-1:0] react_time,
  output logic             time_valid,
  output logic             false_start,
  output logic             pattern_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMING = 2'd1;
  localparam logic [1:0] ALL_ON = 2'd2;
  localparam logic [1:0] TIMING = 2'd3;

  localparam logic [3:0] FULL = 4'(WIDTH);

  logic [1:0]       state, state_n;
  logic             trig_q;
  logic             trig_edge;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [WIDTH:0]   lights_ext;
  logic             legal;
  logic [3:0]       lvl;
  logic             step_ok;
  logic             all_off, all_on;
  logic             set_fs, clr_fs, err, valid;

  assign trig_edge  = trigger & ~trig_q;
  assign lights_ext = {1'b0, lights_in};
  // A thermometer code x has no set bit above its lowest clear bit,
  // so x & (x+1) is zero exactly for the legal patterns.
  assign legal      = ((lights_ext & (lights_ext + 1'b1)) == '0);
  assign all_off    = (lights_in == '0);
  assign all_on     = (lights_in == '1);

  always_comb begin
    lvl = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      lvl = lvl + 4'(lights_in[i]);
    end
  end

  // Previous level is the registered one; a stable pattern is always legal.
  assign step_ok = (lvl == lights_level) || (lvl == lights_level + 4'd1) ||
                   (lvl == 4'd0);

  assign cnt_inc = (tick && (cnt != '1)) ? cnt + 1'b1 : cnt;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    set_fs  = 1'b0;
    clr_fs  = 1'b0;
    err     = 1'b0;
    valid   = 1'b0;
    case (state)
      IDLE: begin
        if (!legal) begin
          err = 1'b1;
        end else if (lvl == 4'd1) begin
          state_n = ARMING;
          clr_fs  = 1'b1;
        end
      end
      ARMING: begin
        if (trig_edge) begin
          set_fs  = 1'b1;
          state_n = IDLE;
        end else if (!legal || !step_ok) begin
          err     = 1'b1;
          state_n = IDLE;
        end else if (lvl == 4'd0) begin
          state_n = IDLE;
        end else if (lvl == FULL) begin
          state_n = ALL_ON;
        end
      end
      ALL_ON: begin
        if (trig_edge) begin
          set_fs  = 1'b1;
          state_n = IDLE;
        end else if (all_off) begin
          state_n = TIMING;
          cnt_n   = '0;
        end else if (!all_on) begin
          err     = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin // TIMING
        if (trig_edge) begin
          valid   = 1'b1;
          state_n = IDLE;
        end else if (!all_off) begin
          err     = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      trig_q       <= 1'b1;
      lights_level <= '0;
      busy         <= 1'b0;
      react_time   <= '0;
      time_valid   <= 1'b0;
      false_start  <= 1'b0;
      pattern_err  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      trig_q      <= trigger;
      busy        <= (state_n != IDLE);
      time_valid  <= valid;
      pattern_err <= err;
      if (legal) begin
        lights_level <= lvl;
      end
      if (valid) begin
        react_time <= cnt_inc;
      end
      if (set_fs) begin
        false_start <= 1'b1;
      end else if (clr_fs) begin
        false_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_f1_light_monitor.sv
module tb_f1_light_monitor;

  typedef struct packed {
    logic        kind;   // 0: time_valid with value, 1: pattern_err
    logic [15:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  lights_in, lights2;
  logic        tick, tick2, trigger, trigger2;
  logic [3:0]  lights_level, lights_level2;
  logic        busy, busy2;
  logic [15:0] react_time;
  logic [3:0]  react_time2;
  logic        time_valid, time_valid2;
  logic        false_start, false_start2;
  logic        pattern_err, pattern_err2;

  int   checks = 0;
  int   errors = 0;
  ev_t  q1[$];
  ev_t  q2[$];

  always #5 clk = ~clk;

  f1_light_monitor #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .lights_in(lights_in), .tick(tick), .trigger(trigger),
    .lights_level(lights_level), .busy(busy), .react_time(react_time),
    .time_valid(time_valid), .false_start(false_start), .pattern_err(pattern_err)
  );

  f1_light_monitor #(.WIDTH(8), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .lights_in(lights2), .tick(tick2), .trigger(trigger2),
    .lights_level(lights_level2), .busy(busy2), .react_time(react_time2),
    .time_valid(time_valid2), .false_start(false_start2), .pattern_err(pattern_err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] l, input logic t, input logic g);
    lights_in = l;
    tick      = t;
    trigger   = g;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc2(input logic [7:0] l, input logic t, input logic g);
    lights2  = l;
    tick2    = t;
    trigger2 = g;
    @(posedge clk);
    #1;
  endtask

  task automatic to_all_on(input int reps);
    logic [7:0] p;
    p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      p = {p[6:0], 1'b1};
      for (int r = 0; r < reps; r++) cyc(p, 1'b0, 1'b0);
    end
  endtask

  // Output monitor: pops the scoreboard whenever a DUT reports an event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (time_valid || pattern_err) begin
          checks++;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL dut_event: unexpected tv=%0b pe=%0b react=%0d", time_valid, pattern_err, react_time);
          end else begin
            e = q1.pop_front();
            if ((e.kind && !(pattern_err && !time_valid)) ||
                (!e.kind && !(time_valid && !pattern_err && react_time == e.val))) begin
              errors++;
              $display("FAIL dut_event: got tv=%0b pe=%0b react=%0d, expected kind=%0d react=%0d",
                       time_valid, pattern_err, react_time, e.kind, e.val);
            end
          end
        end
        if (time_valid2 || pattern_err2) begin
          checks++;
          if (q2.size() == 0) begin
            errors++;
            $display("FAIL dut2_event: unexpected tv=%0b pe=%0b react=%0d", time_valid2, pattern_err2, react_time2);
          end else begin
            e = q2.pop_front();
            if ((e.kind && !(pattern_err2 && !time_valid2)) ||
                (!e.kind && !(time_valid2 && !pattern_err2 && 16'(react_time2) == e.val))) begin
              errors++;
              $display("FAIL dut2_event: got tv=%0b pe=%0b react=%0d, expected kind=%0d react=%0d",
                       time_valid2, pattern_err2, react_time2, e.kind, e.val);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    lights_in = 8'h00; tick = 1'b0; trigger = 1'b0;
    lights2 = 8'h00; tick2 = 1'b0; trigger2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_level", lights_level, 0);
    chk("reset_react", react_time, 0);
    chk("reset_fs", false_start, 0);
    chk("reset2_react", react_time2, 0);
    rst = 1'b0;
    cyc(8'h00, 0, 0);

    // 1: full legal sequence, 10 ticks, press
    to_all_on(4);
    chk("t1_busy_allon", busy, 1);
    chk("t1_level_allon", lights_level, 8);
    cyc(8'h00, 0, 0);
    chk("t1_busy_timing", busy, 1);
    chk("t1_level_off", lights_level, 0);
    for (int i = 0; i < 20; i++) cyc(8'h00, (i % 2) == 0, 0);
    q1.push_back('{kind: 1'b0, val: 16'd10});
    cyc(8'h00, 0, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_react_held", react_time, 10);
    cyc(8'h00, 0, 0);
    chk("t1_react_hold2", react_time, 10);

    // 2: press during ARMING at 1F
    cyc(8'h01, 0, 0); cyc(8'h03, 0, 0); cyc(8'h07, 0, 0); cyc(8'h0F, 0, 0); cyc(8'h1F, 0, 0);
    cyc(8'h1F, 0, 1);
    chk("t2_false_start", false_start, 1);
    chk("t2_busy", busy, 0);
    cyc(8'h1F, 0, 0);
    cyc(8'h00, 0, 0);
    chk("t2_fs_sticky", false_start, 1);
    cyc(8'h01, 0, 0);
    chk("t2_fs_cleared", false_start, 0);
    chk("t2_busy_arm", busy, 1);
    cyc(8'h00, 0, 0);
    chk("t2_abort_idle", busy, 0);

    // 3: skipped step 03 -> 0F
    cyc(8'h01, 0, 0); cyc(8'h03, 0, 0);
    q1.push_back('{kind: 1'b1, val: 16'd0});
    cyc(8'h0F, 0, 0);
    chk("t3_level", lights_level, 4);
    chk("t3_busy", busy, 0);
    cyc(8'h00, 0, 0);

    // 4: illegal pattern in IDLE
    q1.push_back('{kind: 1'b1, val: 16'd0});
    cyc(8'h05, 0, 0);
    chk("t4_level_hold", lights_level, 0);
    chk("t4_busy", busy, 0);
    cyc(8'h00, 0, 0);

    // Press in the same cycle lights go out is still a false start
    to_all_on(1);
    cyc(8'h00, 0, 1);
    chk("t4b_false_start", false_start, 1);
    chk("t4b_busy", busy, 0);
    cyc(8'h00, 0, 0);

    // Edge with nonzero lights during TIMING: result wins, includes this tick
    to_all_on(1);
    cyc(8'h00, 0, 0);
    cyc(8'h00, 1, 0); cyc(8'h00, 1, 0);
    q1.push_back('{kind: 1'b0, val: 16'd3});
    cyc(8'h01, 1, 1);
    chk("t4c_react", react_time, 3);
    cyc(8'h00, 0, 0);

    // 5: saturation on the CNT_W=4 instance
    begin
      logic [7:0] p;
      p = 8'h00;
      for (int n = 0; n < 8; n++) begin
        p = {p[6:0], 1'b1};
        cyc2(p, 0, 0);
      end
    end
    cyc2(8'h00, 0, 0);
    chk("t5_busy", busy2, 1);
    for (int i = 0; i < 20; i++) cyc2(8'h00, 1, 0);
    q2.push_back('{kind: 1'b0, val: 16'd15});
    cyc2(8'h00, 0, 1);
    chk("t5_react_sat", react_time2, 15);
    cyc2(8'h00, 0, 0);

    // 6: reset mid-TIMING with trigger held
    to_all_on(1);
    cyc(8'h00, 0, 0);
    cyc(8'h00, 1, 0);
    trigger = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_busy_rst", busy, 0);
    chk("t6_react_rst", react_time, 0);
    chk("t6_level_rst", lights_level, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(8'h00, 1, 1); cyc(8'h00, 1, 1); cyc(8'h00, 0, 1);
    chk("t6_busy_after", busy, 0);
    chk("t6_react_after", react_time, 0);
    chk("t6_fs_after", false_start, 0);
    cyc(8'h00, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb1_drained", q1.size(), 0);
    chk("sb2_drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
